// File: rtl/clock_pkg.sv
// clock_pkg: shared state encodings and time limits for the clock-setting logic
package clock_pkg;
   typedef enum logic [1:0] {
      RUN      = 2'd0,
      SET_HOUR = 2'd1,
      SET_MIN  = 2'd2,
      LOAD     = 2'd3
   } set_state_t;
   localparam logic [5:0] HOUR_MAX = 6'd23;
   localparam logic [5:0] MIN_MAX  = 6'd59;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronizes a raw button, debounces it on sample strobes, and flags presses
module btn_debounce #(
   parameter int DEB_SAMPLES = 3
) (
   input  logic clk,
   input  logic RESETn,
   input  logic sample_en,
   input  logic btn,
   output logic press
);
   localparam int CW = $clog2(DEB_SAMPLES + 1);
   logic [1:0]    sync;
   logic          level;
   logic          level_q;
   logic [CW-1:0] cnt;
   // sync chain, then accept a new level only after DEB_SAMPLES agreeing differing samples
   always_ff @(posedge clk or negedge RESETn) begin
      if (!RESETn) begin
         sync    <= '0;
         level   <= 1'b0;
         level_q <= 1'b0;
         cnt     <= '0;
      end else begin
         sync    <= {sync[0], btn};
         level_q <= level;
         if (sample_en) begin
            if (sync[1] == level) cnt <= '0;
            else if (cnt == CW'(DEB_SAMPLES - 1)) begin
               level <= sync[1];
               cnt   <= '0;
            end else cnt <= cnt + 1'b1;
         end
      end
   end
   assign press = level & ~level_q;
endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: two-button hour/minute editor that loads the time counter on exit
module time_set_ctrl
   import clock_pkg::*;
#(
   parameter int DEB_SAMPLES = 3
) (
   input  logic       clk,
   input  logic       RESETn,
   input  logic       sample_en,
   input  logic       blink_clk,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic [5:0] cur_hour,
   input  logic [5:0] cur_min,
   output logic       run_en,
   output logic       load,
   output logic [5:0] data_hour,
   output logic [5:0] data_min,
   output logic [5:0] data_sec,
   output logic [1:0] set_mode,
   output logic       blank_hour,
   output logic       blank_min
);
   set_state_t state, state_d;
   logic [5:0] edit_hour, edit_min, hour_d, min_d;
   logic       mode_press, inc_press, inc_ok;
   btn_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb_mode (
      .clk(clk), .RESETn(RESETn), .sample_en(sample_en), .btn(btn_mode), .press(mode_press)
   );
   btn_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb_inc (
      .clk(clk), .RESETn(RESETn), .sample_en(sample_en), .btn(btn_inc), .press(inc_press)
   );
   assign inc_ok = inc_press & ~mode_press;
   // next state and edit values; a mode press always wins over a simultaneous inc
   always_comb begin
      state_d = state;
      hour_d  = edit_hour;
      min_d   = edit_min;
      case (state)
         RUN: if (mode_press) begin
            state_d = SET_HOUR;
            hour_d  = cur_hour;
            min_d   = cur_min;
         end
         SET_HOUR: begin
            state_d = mode_press ? SET_MIN : SET_HOUR;
            hour_d  = inc_ok ? ((edit_hour == HOUR_MAX) ? 6'd0 : edit_hour + 6'd1) : edit_hour;
         end
         SET_MIN: begin
            state_d = mode_press ? LOAD : SET_MIN;
            min_d   = inc_ok ? ((edit_min == MIN_MAX) ? 6'd0 : edit_min + 6'd1) : edit_min;
         end
         LOAD: state_d = RUN;
         default: state_d = RUN;
      endcase
   end
   // state, edit registers and registered blink masks
   always_ff @(posedge clk or negedge RESETn) begin
      if (!RESETn) begin
         state      <= RUN;
         edit_hour  <= '0;
         edit_min   <= '0;
         blank_hour <= 1'b0;
         blank_min  <= 1'b0;
      end else begin
         state      <= state_d;
         edit_hour  <= hour_d;
         edit_min   <= min_d;
         blank_hour <= (state == SET_HOUR) & blink_clk;
         blank_min  <= (state == SET_MIN) & blink_clk;
      end
   end
   assign run_en    = (state == RUN) | (state == LOAD);
   assign load      = (state == LOAD);
   assign set_mode  = state;
   assign data_hour = edit_hour;
   assign data_min  = edit_min;
   assign data_sec  = 6'd0;
endmodule
